jtag_dtm: RTL and testbench
===========================

Name: jtag_dtm

Overview:
- JTAG Debug Transport Module: the initiator end of the debug-module interface (DMI) whose responder is the debug module.
- Oversamples the board JTAG pins (TCK, TMS, TDI) in the clk domain and runs an IEEE 1149.1 TAP controller.
- Implements the RISC-V debug-spec IDCODE, DTMCS, DMI and BYPASS registers.
- Converts DMI scans into valid/ready read/write requests towards the debug module, and returns the responses to the next scan.

Parameters:
IDCODE_VAL, 32'h1AB0_0A53, value of the IDCODE register; bit 0 must be 1.
ABITS, 7, DMI address width.
IR_LEN, 5, instruction register length.

Ports:
clk  input  1  system clock.
rst_ni  input  1  asynchronous, active-low reset.
tck_i  input  1  JTAG TCK, asynchronous; must satisfy f(TCK) <= f(clk)/6.
tms_i  input  1  JTAG TMS, asynchronous.
tdi_i  input  1  JTAG TDI, asynchronous.
tdo_o  output  1  JTAG TDO.
tdo_oe_o  output  1  TDO drive enable; high only in Shift-IR and Shift-DR.
dmi_req_valid_o  output  1  DMI request valid.
dmi_req_ready_i  input  1  DMI request accepted.
dmi_req_addr_o  output  ABITS  DMI register address.
dmi_req_data_o  output  32  DMI write data.
dmi_req_op_o  output  2  1 = read, 2 = write.
dmi_resp_valid_i  input  1  DMI response valid.
dmi_resp_ready_o  output  1  response accept.
dmi_resp_data_i  input  32  DMI read data.
dmi_resp_err_i  input  1  response failed.
dmi_hardreset_o  output  1  one-cycle pulse on a dtmcs.dmihardreset write.

Behaviour:
- **Reset values.** All outputs are 0. TAP is in Test-Logic-Reset, IR = 5'h01 (IDCODE), DMI FSM is IDLE, sticky dmistat = 0, captured DMI = 0.
- **Synchronisers.** tck, tms and tdi each pass through a 2-flop synchroniser; a third tck flop provides edge detection.
  - Rising edge (tck_q2 & ~tck_q3): sample tms/tdi, advance the TAP, shift the selected register.
  - Falling edge: load tdo_o from the LSB of the active shift register.
  - tdo_o is registered and held between falling edges.
- **TAP.** Standard 16-state 1149.1 FSM.
  - Five consecutive TMS=1 rising edges from any state reach Test-Logic-Reset.
  - Test-Logic-Reset forces IR = IDCODE and clears the DTMCS shift register.
- **IR.** Capture-IR loads 5'b00001. Shift-IR shifts LSB first. Update-IR latches the value.
  - Decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI.
  - Any other value, including 0x1F, selects BYPASS (1 bit, captures 0).
- **IDCODE.** Capture-DR loads IDCODE_VAL.
- **DTMCS.** Capture-DR loads: [3:0] = 1, [9:4] = ABITS, [11:10] = dmistat, [14:12] = 1, all other bits 0.
  - Update-DR with bit 16 set: clear sticky dmistat.
  - Update-DR with bit 17 set: clear dmistat, return the DMI FSM to IDLE (dropping any pending request), pulse dmi_hardreset_o.
- **DMI register.** ABITS+34 bits: {addr, data[31:0], op[1:0]}.
  - Capture-DR loads {last_addr, last_rdata, op_status}.
  - op_status = 3 if the FSM is not IDLE, else the sticky dmistat.
  - If Capture-DR occurs while the FSM is not IDLE, sticky dmistat becomes 3 (busy).
- **Update-DR on DMI.**
  - op = 1 or 2, dmistat == 0 and FSM IDLE: latch addr/data/op and enter REQ the next clk.
  - FSM busy: dmistat becomes 3 and the request is discarded.
  - dmistat != 0: the request is ignored.
  - op = 0: no-op.
- **DMI FSM.**
  - IDLE -> REQ on a valid Update-DR.
  - REQ: dmi_req_valid_o = 1 with stable addr/data/op until dmi_req_ready_i. Same-cycle handshake moves to RESP.
  - RESP: dmi_resp_ready_o = 1. On dmi_resp_valid_i:
    - latch last_rdata = dmi_resp_data_i for reads; keep the previous value for writes;
    - set dmistat = 2 if dmi_resp_err_i (sticky);
    - return to IDLE.
  - last_addr is always updated to the request address.
- **Reset mid-operation.** rst_ni low at any point restores all reset values immediately. A pending request is dropped; the responder must also be reset.
- **Simultaneous events.** If dmireset/hardreset Update-DR coincides with a response, the response data is still latched and dmistat ends 0.
- **Latency.** Update-DR rising TCK edge to dmi_req_valid_o = 1 is at most 4 clk.

Test Plan:
- Reset, then 5 TCK with TMS=1, then Shift-DR for 32 bits -> TDO stream LSB-first equals 0x1AB00A53; tdo_oe_o is high only during the shift.
- IR=0x10, Capture/Shift DTMCS -> 0x00001071 (version 1, abits 7, idle 1, dmistat 0).
- IR=0x11, shift {addr=0x11, data=0, op=1}, responder ready after 2 clk returning 0x00030382 -> next DMI scan captures {0x11, 0x00030382, 0}.
- Write {addr=0x10, data=0x00000001, op=2} -> dmi_req_valid_o high with addr 0x10 and data 0x1 until ready; a read issued afterwards keeps last_rdata unchanged.
- Hold dmi_req_ready_i low and perform a second DMI scan -> captured op = 3, DTMCS dmistat = 3; DTMCS write bit16 -> dmistat 0; write bit17 -> one-cycle dmi_hardreset_o and FSM IDLE.
- dmi_resp_err_i = 1 on a read -> captured op = 2 persists across scans and new requests are ignored until a dmireset; deasserting rst_ni mid-REQ -> dmi_req_valid_o = 0 the next clk.

Source files
------------

// File: rtl/jtag_dtm.sv
// rtl/jtag_dtm.sv - JTAG debug transport module: oversampled TAP plus DMI request/response bridge
// TCK/TMS/TDI are sampled in the clk domain; DMI scans become valid/ready requests to the debug module.
module jtag_dtm #(
    parameter logic [31:0] IDCODE_VAL = 32'h1AB0_0A53,
    parameter int unsigned ABITS      = 7,
    parameter int unsigned IR_LEN     = 5
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             tck_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    output logic             tdo_oe_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [31:0]      dmi_req_data_o,
    output logic [1:0]       dmi_req_op_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic             dmi_resp_err_i,
    output logic             dmi_hardreset_o
);

    localparam int unsigned       DMI_W     = ABITS + 34;
    localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(5'h01);
    localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'(5'h10);
    localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'(5'h11);
    localparam logic [5:0]        ABITS_F   = 6'(ABITS);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_RESP} dmi_state_e;

    logic [2:0] tck_sync_q;
    logic [1:0] tms_sync_q, tdi_sync_q;
    logic       tck_rise, tck_fall, tms, tdi;

    tap_state_e        tap_state_q, tap_state_d, tap_next;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
    logic [DMI_W-1:0]  dr_q, dr_d, dr_shifted;
    logic              tdo_q, tdo_d;
    dmi_state_e        dmi_state_q, dmi_state_d;
    logic [1:0]        dmistat_q, dmistat_d;
    logic [ABITS-1:0]  req_addr_q, req_addr_d, last_addr_q, last_addr_d;
    logic [31:0]       req_data_q, req_data_d, last_rdata_q, last_rdata_d;
    logic [1:0]        req_op_q, req_op_d;
    logic              hardreset_q, hardreset_d;

    logic [31:0] dtmcs_capture;
    logic [1:0]  op_status;
    logic        cap_busy, upd_busy, launch, stat_clr, hard_clr;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
        end else begin
            tck_sync_q <= {tck_sync_q[1:0], tck_i};
            tms_sync_q <= {tms_sync_q[0], tms_i};
            tdi_sync_q <= {tdi_sync_q[0], tdi_i};
        end
    end

    assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
    assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
    assign tms      = tms_sync_q[1];
    assign tdi      = tdi_sync_q[1];

    always_comb begin
        tap_next = tap_state_q;
        case (tap_state_q)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PAU_DR;
            PAU_DR:  tap_next = tms ? EX2_DR : PAU_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PAU_IR;
            PAU_IR:  tap_next = tms ? EX2_IR : PAU_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    // One physical shift register serves every DR; TDI enters at the selected register's MSB.
    always_comb begin
        dr_shifted = dr_q >> 1;
        case (ir_q)
            IR_IDCODE, IR_DTMCS: dr_shifted[31]       = tdi;
            IR_DMI:              dr_shifted[DMI_W-1]  = tdi;
            default:             dr_shifted[0]        = tdi;
        endcase
    end

    assign dtmcs_capture = {17'b0, 3'd1, dmistat_q, ABITS_F, 4'd1};
    assign op_status     = (dmi_state_q != DMI_IDLE) ? 2'd3 : dmistat_q;

    always_comb begin
        tap_state_d  = tap_state_q;
        ir_shift_d   = ir_shift_q;
        ir_d         = ir_q;
        dr_d         = dr_q;
        tdo_d        = tdo_q;
        dmi_state_d  = dmi_state_q;
        dmistat_d    = dmistat_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;
        last_addr_d  = last_addr_q;
        last_rdata_d = last_rdata_q;
        hardreset_d  = 1'b0;
        cap_busy     = 1'b0;
        upd_busy     = 1'b0;
        launch       = 1'b0;
        stat_clr     = 1'b0;
        hard_clr     = 1'b0;

        if (tck_fall) begin
            tdo_d = (tap_state_q == SH_IR) ? ir_shift_q[0] : dr_q[0];
        end

        if (tck_rise) begin
            tap_state_d = tap_next;
            case (tap_state_q)
                TLR: begin
                    ir_d = IR_IDCODE;
                    dr_d = '0;
                end
                CAP_IR: ir_shift_d = IR_LEN'(1);
                SH_IR:  ir_shift_d = {tdi, ir_shift_q[IR_LEN-1:1]};
                UPD_IR: ir_d = ir_shift_q;
                CAP_DR: begin
                    case (ir_q)
                        IR_IDCODE: dr_d = DMI_W'(IDCODE_VAL);
                        IR_DTMCS:  dr_d = DMI_W'(dtmcs_capture);
                        IR_DMI: begin
                            dr_d     = {last_addr_q, last_rdata_q, op_status};
                            cap_busy = (dmi_state_q != DMI_IDLE);
                        end
                        default:   dr_d = '0;
                    endcase
                end
                SH_DR:  dr_d = dr_shifted;
                UPD_DR: begin
                    if (ir_q == IR_DTMCS) begin
                        stat_clr = dr_q[16] | dr_q[17];
                        hard_clr = dr_q[17];
                    end else if (ir_q == IR_DMI && (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
                        if (dmi_state_q != DMI_IDLE) begin
                            upd_busy = 1'b1;
                        end else if (dmistat_q == 2'd0) begin
                            launch = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (dmi_state_q)
            DMI_REQ: begin
                if (dmi_req_ready_i) dmi_state_d = DMI_RESP;
            end
            DMI_RESP: begin
                if (dmi_resp_valid_i) begin
                    if (req_op_q == 2'd1) last_rdata_d = dmi_resp_data_i;
                    if (dmi_resp_err_i) dmistat_d = 2'd2;
                    dmi_state_d = DMI_IDLE;
                end
            end
            default: ;
        endcase

        if (cap_busy || upd_busy) dmistat_d = 2'd3;

        if (launch) begin
            req_addr_d  = dr_q[DMI_W-1:34];
            req_data_d  = dr_q[33:2];
            req_op_d    = dr_q[1:0];
            last_addr_d = dr_q[DMI_W-1:34];
            dmi_state_d = DMI_REQ;
        end

        // Resets win over a same-cycle response status, but the response data is still kept.
        if (stat_clr) dmistat_d = 2'd0;
        if (hard_clr) begin
            dmi_state_d = DMI_IDLE;
            hardreset_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_state_q  <= TLR;
            ir_shift_q   <= '0;
            ir_q         <= IR_IDCODE;
            dr_q         <= '0;
            tdo_q        <= 1'b0;
            dmi_state_q  <= DMI_IDLE;
            dmistat_q    <= 2'd0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= 2'd0;
            last_addr_q  <= '0;
            last_rdata_q <= '0;
            hardreset_q  <= 1'b0;
        end else begin
            tap_state_q  <= tap_state_d;
            ir_shift_q   <= ir_shift_d;
            ir_q         <= ir_d;
            dr_q         <= dr_d;
            tdo_q        <= tdo_d;
            dmi_state_q  <= dmi_state_d;
            dmistat_q    <= dmistat_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_op_q     <= req_op_d;
            last_addr_q  <= last_addr_d;
            last_rdata_q <= last_rdata_d;
            hardreset_q  <= hardreset_d;
        end
    end

    assign tdo_o            = tdo_q;
    assign tdo_oe_o         = (tap_state_q == SH_DR) || (tap_state_q == SH_IR);
    assign dmi_req_valid_o  = (dmi_state_q == DMI_REQ);
    assign dmi_resp_ready_o = (dmi_state_q == DMI_RESP);
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_jtag_dtm.sv
// tb/tb_jtag_dtm.sv - self-checking bench for jtag_dtm with a debug-module responder and scan-level model
module tb_jtag_dtm;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tck_i = 1'b0, tms_i = 1'b0, tdi_i = 1'b0;
    logic        tdo_o, tdo_oe_o;
    logic        dmi_req_valid_o, dmi_req_ready_i;
    logic [6:0]  dmi_req_addr_o;
    logic [31:0] dmi_req_data_o;
    logic [1:0]  dmi_req_op_o;
    logic        dmi_resp_valid_i, dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic        dmi_resp_err_i;
    logic        dmi_hardreset_o;

    jtag_dtm dut (
        .clk(clk), .rst_ni(rst_ni), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o), .dmi_req_op_o(dmi_req_op_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_err_i(dmi_resp_err_i),
        .dmi_hardreset_o(dmi_hardreset_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
        logic [1:0]  op;
    } req_t;

    req_t        req_q[$];
    logic [31:0] mem [128];
    bit          hold_ready = 1'b0;
    bit          rsp_err = 1'b0;
    int          rdy_dly = 0, rsp_dly = 0;
    int          hr_cnt = 0;

    always @(negedge clk) if (dmi_hardreset_o) hr_cnt <= hr_cnt + 1;

    // Debug-module responder: register file, configurable delays and error injection.
    initial begin
        req_t cur;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_err_i   = 1'b0;
        dmi_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (dmi_req_valid_o && !hold_ready) begin
                repeat (rdy_dly) @(negedge clk);
                cur = '{a: dmi_req_addr_o, d: dmi_req_data_o, op: dmi_req_op_o};
                dmi_req_ready_i = 1'b1;
                @(negedge clk);
                dmi_req_ready_i = 1'b0;
                req_q.push_back(cur);
                repeat (rsp_dly) @(negedge clk);
                dmi_resp_err_i  = rsp_err;
                if (rsp_err)          dmi_resp_data_i = 32'hBAD0_0000 | 32'(cur.a);
                else if (cur.op == 1) dmi_resp_data_i = mem[cur.a];
                else                  dmi_resp_data_i = 32'hFFFF_FFFF;
                if (!rsp_err && cur.op == 2) mem[cur.a] = cur.d;
                dmi_resp_valid_i = 1'b1;
                @(negedge clk);
                dmi_resp_valid_i = 1'b0;
                dmi_resp_err_i   = 1'b0;
            end
        end
    end

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
        tms_i = tms;
        tdi_i = tdi;
        repeat (4) @(negedge clk);
        tdo = tdo_o;
        oe  = tdo_oe_o;
        tck_i = 1'b1;
        repeat (4) @(negedge clk);
        tck_i = 1'b0;
    endtask

    task automatic idle(input int n);
        logic t, o;
        repeat (n) tck_cycle(1'b0, 1'b0, t, o);
    endtask

    task automatic tap_reset();
        logic t, o;
        repeat (5) tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
        logic t, o;
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], t, o);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [4:0] d;
        scan_ir(v, d);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int len, output logic [63:0] dout, output logic oe_ok);
        logic t, o;
        dout  = '0;
        oe_ok = 1'b1;
        tck_cycle(1'b1, 1'b0, t, o); oe_ok &= ~o;
        tck_cycle(1'b0, 1'b0, t, o); oe_ok &= ~o;
        tck_cycle(1'b0, 1'b0, t, o); oe_ok &= ~o;
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], t, o);
            dout[i] = t;
            oe_ok &= o;
        end
        tck_cycle(1'b1, 1'b0, t, o); oe_ok &= ~o;
        tck_cycle(1'b0, 1'b0, t, o); oe_ok &= ~o;
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op, output logic [63:0] cap);
        logic ok;
        scan_dr(64'({a, d, op}), 41, cap, ok);
    endtask

    task automatic dtmcs_scan(input logic [31:0] v, output logic [63:0] cap);
        logic ok;
        scan_dr(64'(v), 32, cap, ok);
    endtask

    task automatic pop_req(input string tag, input logic [40:0] exp);
        req_t r;
        chk({tag, "_cnt"}, 64'(req_q.size()), 64'd1);
        if (req_q.size() > 0) begin
            r = req_q.pop_front();
            chk(tag, 64'(r), 64'(exp));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        logic [63:0] v;
        logic [4:0]  irv;
        logic        ok;
        logic [6:0]  m_addr, ra;
        logic [31:0] m_rdata, rd, exp_rd;
        logic [1:0]  m_stat, rop;
        logic        will_launch;

        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[7'h11] = 32'h0003_0382;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tdo_o, tdo_oe_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_hardreset_o,
                                  dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        tap_reset();
        scan_dr(64'd0, 32, v, ok);
        chk("idcode", v, 64'h1AB0_0A53);
        chk("idcode_oe", 64'(ok), 64'd1);

        scan_ir(5'h10, irv);
        chk("ir_capture", 64'(irv), 64'd1);
        dtmcs_scan(32'd0, v);
        chk("dtmcs_idle", v, 64'h1071);

        set_ir(5'h1F);
        scan_dr(64'hA5, 8, v, ok);
        chk("bypass_1f", v, 64'h4A);
        chk("bypass_oe", 64'(ok), 64'd1);
        set_ir(5'h05);
        scan_dr(64'h3C, 8, v, ok);
        chk("bypass_05", v, 64'h78);

        set_ir(5'h11);
        rdy_dly = 2; rsp_dly = 1; rsp_err = 1'b0;
        dmi_scan(7'h11, 32'd0, 2'd1, v);
        chk("dmi_cap_reset", v, 64'd0);
        idle(2);
        pop_req("rd11_req", {7'h11, 32'd0, 2'd1});
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_rd11", v, 64'({7'h11, 32'h0003_0382, 2'd0}));

        hold_ready = 1'b1;
        dmi_scan(7'h10, 32'h1, 2'd2, v);
        chk("wr_valid", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
            64'({1'b1, 7'h10, 32'h1, 2'd2}));
        repeat (10) @(negedge clk);
        chk("wr_stable", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
            64'({1'b1, 7'h10, 32'h1, 2'd2}));
        hold_ready = 1'b0;
        idle(2);
        pop_req("wr10_req", {7'h10, 32'h1, 2'd2});
        dmi_scan(7'h10, 32'd0, 2'd1, v);
        chk("dmi_cap_wr10", v, 64'({7'h10, 32'h0003_0382, 2'd0}));
        idle(2);
        pop_req("rd10_req", {7'h10, 32'd0, 2'd1});

        hold_ready = 1'b1;
        dmi_scan(7'h12, 32'd0, 2'd1, v);
        chk("dmi_cap_rd10", v, 64'({7'h10, 32'h1, 2'd0}));
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_busy", v, 64'({7'h12, 32'h1, 2'd3}));
        set_ir(5'h10);
        dtmcs_scan(32'h0001_0000, v);
        chk("dtmcs_busy", v, 64'h1C71);
        dtmcs_scan(32'd0, v);
        chk("dtmcs_cleared", v, 64'h1071);
        chk("busy_still_req", 64'(dmi_req_valid_o), 64'd1);
        hr_cnt = 0;
        dtmcs_scan(32'h0002_0000, v);
        chk("dtmcs_pre_hard", v, 64'h1071);
        chk("hardreset_pulse", 64'(hr_cnt), 64'd1);
        chk("hardreset_drop", 64'(dmi_req_valid_o), 64'd0);
        hold_ready = 1'b0;
        set_ir(5'h11);
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_after_hard", v, 64'({7'h12, 32'h1, 2'd0}));
        chk("no_req_after_hard", 64'(req_q.size()), 64'd0);

        rdy_dly = 0; rsp_dly = 0; rsp_err = 1'b1;
        dmi_scan(7'h20, 32'd0, 2'd1, v);
        idle(2);
        rsp_err = 1'b0;
        pop_req("err_req", {7'h20, 32'd0, 2'd1});
        dmi_scan(7'h21, 32'd0, 2'd1, v);
        chk("dmi_cap_err", v, 64'({7'h20, 32'hBAD0_0020, 2'd2}));
        idle(2);
        chk("err_ignored", 64'(req_q.size()), 64'd0);
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_err_sticky", v, 64'({7'h20, 32'hBAD0_0020, 2'd2}));
        set_ir(5'h10);
        dtmcs_scan(32'h0001_0000, v);
        chk("dtmcs_err", v, 64'h1871);
        set_ir(5'h11);
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_err_clear", v, 64'({7'h20, 32'hBAD0_0020, 2'd0}));

        m_addr = 7'h20; m_rdata = 32'hBAD0_0020; m_stat = 2'd0;
        for (int n = 0; n < 30; n++) begin
            ra = 7'($urandom_range(0, 127));
            rd = $urandom;
            rop = 2'($urandom_range(0, 2));
            rsp_err = ($urandom_range(0, 5) == 0);
            rdy_dly = $urandom_range(0, 3);
            rsp_dly = $urandom_range(0, 3);
            will_launch = (rop != 2'd0) && (m_stat == 2'd0);
            exp_rd = rsp_err ? (32'hBAD0_0000 | 32'(ra)) : mem[ra];
            dmi_scan(ra, rd, rop, v);
            chk("rnd_cap", v, 64'({m_addr, m_rdata, m_stat}));
            idle(2);
            if (will_launch) begin
                pop_req("rnd_req", {ra, rd, rop});
                m_addr = ra;
                if (rop == 2'd1) m_rdata = exp_rd;
                if (rsp_err) m_stat = 2'd2;
            end else begin
                chk("rnd_noreq", 64'(req_q.size()), 64'd0);
            end
            if (m_stat != 2'd0 && $urandom_range(0, 1) == 0) begin
                set_ir(5'h10);
                dtmcs_scan(32'h0001_0000, v);
                chk("rnd_dtmcs", v, 64'(32'h1071 | (32'(m_stat) << 10)));
                m_stat = 2'd0;
                set_ir(5'h11);
            end
        end
        rsp_err = 1'b0;

        hold_ready = 1'b1;
        dmi_scan(7'h33, 32'h55, 2'd2, v);
        chk("mid_req_valid", 64'(dmi_req_valid_o), 64'd1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("rst_drops_valid", 64'(dmi_req_valid_o), 64'd0);
        @(negedge clk);
        chk("rst_outputs", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'd0);
        rst_ni = 1'b1;
        hold_ready = 1'b0;
        repeat (2) @(negedge clk);
        tap_reset();
        scan_dr(64'd0, 32, v, ok);
        chk("idcode_after_rst", v, 64'h1AB0_0A53);
        set_ir(5'h11);
        dmi_scan(7'h00, 32'd0, 2'd0, v);
        chk("dmi_cap_after_rst", v, 64'd0);
        chk("no_req_after_rst", 64'(req_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
